// File: rtl/volt_cal_sched.sv
// Time-multiplexed AD7606 voltage scheduler: one abs/multiply/shift/BCD datapath
// shared by all channels, results published atomically once per frame.
module volt_cal_sched #(
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned FULL_SCALE = 50000,
  parameter int unsigned SHIFT      = 15
) (
  input  logic                  clk,
  input  logic                  ad_reset,
  input  logic                  ad_valid,
  input  logic [16*NUM_CH-1:0]  ad_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun,
  output logic [20*NUM_CH-1:0]  ch_dec,
  output logic [8*NUM_CH-1:0]   ch_sig
);

  localparam int unsigned CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned SAMP_W  = 16;
  localparam int unsigned DEC_W   = 20;
  localparam int unsigned SIG_W   = 8;
  localparam int unsigned PROD_W  = 32;
  localparam int unsigned NDIG    = 5;
  localparam logic [7:0]  SIG_POS = 8'd43;
  localparam logic [7:0]  SIG_NEG = 8'd45;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABS,
    S_MUL,
    S_SHR,
    S_BCD,
    S_STORE,
    S_DONE
  } state_e;

  state_e                    state_q, state_d;
  logic [SAMP_W*NUM_CH-1:0]  snap_q, snap_d;
  logic [CW-1:0]             ch_idx_q, ch_idx_d;
  logic [SAMP_W-1:0]         mag_q, mag_d;
  logic [SIG_W-1:0]          sign_q, sign_d;
  logic [PROD_W-1:0]         prod_q, prod_d;
  logic [SAMP_W-1:0]         sh_q, sh_d;
  logic [DEC_W-1:0]          bcd_q, bcd_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [DEC_W*NUM_CH-1:0]   sh_dec_q, sh_dec_d;
  logic [SIG_W*NUM_CH-1:0]   sh_sig_q, sh_sig_d;
  logic [DEC_W*NUM_CH-1:0]   ch_dec_q, ch_dec_d;
  logic [SIG_W*NUM_CH-1:0]   ch_sig_q, ch_sig_d;
  logic                      busy_q, busy_d;
  logic                      frame_done_q, frame_done_d;
  logic                      overrun_q, overrun_d;
  logic [SAMP_W-1:0]         cur_x;
  logic [DEC_W-1:0]          bcd_adj;

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;
  assign ch_dec     = ch_dec_q;
  assign ch_sig     = ch_sig_q;

  assign cur_x = snap_q[SAMP_W*int'(ch_idx_q) +: SAMP_W];

  // Double-dabble pre-shift correction: add 3 to every digit that is 5 or more
  always_comb begin
    bcd_adj = bcd_q;
    for (int d = 0; d < int'(NDIG); d++) begin
      if (bcd_adj[4*d +: 4] >= 4'd5) begin
        bcd_adj[4*d +: 4] = bcd_adj[4*d +: 4] + 4'd3;
      end
    end
  end

  // Next-state and datapath sequencing for one frame
  always_comb begin
    state_d      = state_q;
    snap_d       = snap_q;
    ch_idx_d     = ch_idx_q;
    mag_d        = mag_q;
    sign_d       = sign_q;
    prod_d       = prod_q;
    sh_d         = sh_q;
    bcd_d        = bcd_q;
    cnt_d        = cnt_q;
    sh_dec_d     = sh_dec_q;
    sh_sig_d     = sh_sig_q;
    ch_dec_d     = ch_dec_q;
    ch_sig_d     = ch_sig_q;
    frame_done_d = 1'b0;
    overrun_d    = ad_valid && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (ad_valid) begin
          snap_d   = ad_data;
          ch_idx_d = '0;
          state_d  = S_ABS;
        end
      end
      S_ABS: begin
        if (cur_x[SAMP_W-1]) begin
          mag_d  = ~cur_x + 16'd1;
          sign_d = SIG_NEG;
        end else begin
          mag_d  = cur_x;
          sign_d = SIG_POS;
        end
        state_d = S_MUL;
      end
      S_MUL: begin
        prod_d  = PROD_W'(mag_q) * PROD_W'(FULL_SCALE);
        state_d = S_SHR;
      end
      S_SHR: begin
        sh_d    = SAMP_W'(prod_q >> SHIFT);
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = S_BCD;
      end
      S_BCD: begin
        bcd_d = {bcd_adj[DEC_W-2:0], sh_q[SAMP_W-1]};
        sh_d  = {sh_q[SAMP_W-2:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = S_STORE;
        end
      end
      S_STORE: begin
        sh_dec_d[DEC_W*int'(ch_idx_q) +: DEC_W] = bcd_q;
        sh_sig_d[SIG_W*int'(ch_idx_q) +: SIG_W] = sign_q;
        if (ch_idx_q == CW'(NUM_CH - 1)) begin
          state_d = S_DONE;
        end else begin
          ch_idx_d = ch_idx_q + CW'(1);
          state_d  = S_ABS;
        end
      end
      S_DONE: begin
        ch_dec_d     = sh_dec_q;
        ch_sig_d     = sh_sig_q;
        frame_done_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; synchronous reset discards any frame in flight
  always_ff @(posedge clk) begin
    if (ad_reset) begin
      state_q      <= S_IDLE;
      snap_q       <= '0;
      ch_idx_q     <= '0;
      mag_q        <= '0;
      sign_q       <= SIG_POS;
      prod_q       <= '0;
      sh_q         <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      sh_dec_q     <= '0;
      sh_sig_q     <= {NUM_CH{SIG_POS}};
      ch_dec_q     <= '0;
      ch_sig_q     <= {NUM_CH{SIG_POS}};
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      snap_q       <= snap_d;
      ch_idx_q     <= ch_idx_d;
      mag_q        <= mag_d;
      sign_q       <= sign_d;
      prod_q       <= prod_d;
      sh_q         <= sh_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      sh_dec_q     <= sh_dec_d;
      sh_sig_q     <= sh_sig_d;
      ch_dec_q     <= ch_dec_d;
      ch_sig_q     <= ch_sig_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

endmodule

// File: tb/tb_volt_cal_sched.sv
// Bench for volt_cal_sched: frame-level reference model compared every cycle,
// plus literal expectations for the documented scenarios.
module tb_volt_cal_sched;

  localparam int unsigned NUM_CH     = 8;
  localparam int unsigned FULL_SCALE = 50000;
  localparam int unsigned SHIFT      = 15;
  localparam int          LAT        = 161;

  logic                  clk;
  logic                  ad_reset;
  logic                  ad_valid;
  logic [16*NUM_CH-1:0]  ad_data;
  logic                  busy;
  logic                  frame_done;
  logic                  overrun;
  logic [20*NUM_CH-1:0]  ch_dec;
  logic [8*NUM_CH-1:0]   ch_sig;

  volt_cal_sched #(
    .NUM_CH    (NUM_CH),
    .FULL_SCALE(FULL_SCALE),
    .SHIFT     (SHIFT)
  ) dut (
    .clk       (clk),
    .ad_reset  (ad_reset),
    .ad_valid  (ad_valid),
    .ad_data   (ad_data),
    .busy      (busy),
    .frame_done(frame_done),
    .overrun   (overrun),
    .ch_dec    (ch_dec),
    .ch_sig    (ch_sig)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Decimal value of one sample: |x| * FULL_SCALE / 2^SHIFT, as five BCD digits
  function automatic logic [19:0] exp_dec(input logic [15:0] x);
    longint m;
    longint v;
    logic [19:0] r;
    m = longint'(x);
    if (x[15]) m = 65536 - m;
    v = (m * longint'(FULL_SCALE)) / (longint'(1) << SHIFT);
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] exp_sig(input logic [15:0] x);
    return x[15] ? 8'd45 : 8'd43;
  endfunction

  // Frame-level reference: a frame accepted when idle finishes LAT edges later
  logic                  m_active = 1'b0;
  int                    m_age = 0;
  logic                  m_fd = 1'b0;
  logic                  m_ov = 1'b0;
  logic [16*NUM_CH-1:0]  m_snap = '0;
  logic [20*NUM_CH-1:0]  m_dec = '0;
  logic [8*NUM_CH-1:0]   m_sig = '0;

  always @(posedge clk) begin
    if (ad_reset) begin
      m_active <= 1'b0;
      m_age    <= 0;
      m_fd     <= 1'b0;
      m_ov     <= 1'b0;
      m_dec    <= '0;
      m_sig    <= {NUM_CH{8'd43}};
    end else begin
      m_ov <= ad_valid && m_active;
      m_fd <= m_active && (m_age == LAT - 1);
      if (m_active) begin
        m_age <= m_age + 1;
        if (m_age == LAT - 1) begin
          m_active <= 1'b0;
          for (int i = 0; i < int'(NUM_CH); i++) begin
            m_dec[20*i +: 20] <= exp_dec(m_snap[16*i +: 16]);
            m_sig[8*i +: 8]   <= exp_sig(m_snap[16*i +: 16]);
          end
        end
      end else if (ad_valid) begin
        m_active <= 1'b1;
        m_age    <= 0;
        m_snap   <= ad_data;
      end
    end
  end

  int   errors = 0;
  int   checks = 0;
  logic chk_en = 1'b0;
  int   fd_cnt, ov_cnt, busy_cnt, last_fd, prev_fd, ck;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one cycle, compare against the model, and tally pulses
  task automatic step();
    @(negedge clk);
    if (chk_en) begin
      check("busy", 160'(busy), 160'(m_active));
      check("frame_done", 160'(frame_done), 160'(m_fd));
      check("overrun", 160'(overrun), 160'(m_ov));
      check("ch_dec", ch_dec, m_dec);
      check("ch_sig", 160'(ch_sig), 160'(m_sig));
    end
    if (frame_done === 1'b1) begin
      fd_cnt++;
      prev_fd = last_fd;
      last_fd = cyc;
    end
    if (overrun === 1'b1) ov_cnt++;
    if (busy === 1'b1) busy_cnt++;
  endtask

  task automatic clear_counts();
    fd_cnt = 0;
    ov_cnt = 0;
    busy_cnt = 0;
    last_fd = 0;
    prev_fd = 0;
  endtask

  task automatic pulse_valid();
    ad_valid = 1'b1;
    step();
    ad_valid = 1'b0;
    ck = cyc;
  endtask

  task automatic wait_fd();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (frame_done !== 1'b1 && n < 400);
    check("frame_done_seen", 160'(frame_done), 160'(1'b1));
  endtask

  task automatic load_frame(input logic [15:0] v0, input logic [15:0] v1, input logic [15:0] v2,
                            input logic [15:0] v3, input logic [15:0] v4, input logic [15:0] v5,
                            input logic [15:0] v6, input logic [15:0] v7);
    ad_data = {v7, v6, v5, v4, v3, v2, v1, v0};
  endtask

  // Accept one frame and check its latency and busy duration
  task automatic run_frame(input string tag);
    clear_counts();
    pulse_valid();
    wait_fd();
    check({tag, "_latency"}, 160'(cyc - ck), 160'(LAT));
    check({tag, "_busy_cycles"}, 160'(busy_cnt), 160'(LAT));
  endtask

  logic [19:0] t2_dec [5];
  logic [7:0]  t2_sig [5];

  initial begin
    ad_reset = 1'b1;
    ad_valid = 1'b0;
    ad_data  = '0;
    clear_counts();
    step();
    step();
    chk_en = 1'b1;
    check("reset_busy", 160'(busy), 160'(1'b0));
    check("reset_dec", ch_dec, 160'(0));
    check("reset_sig", 160'(ch_sig), 160'({NUM_CH{8'd43}}));
    ad_reset = 1'b0;
    step();

    // Full positive scale on every channel; input changes after accept are ignored
    load_frame(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    clear_counts();
    pulse_valid();
    ad_data = '0;
    wait_fd();
    check("t1_latency", 160'(cyc - ck), 160'(LAT));
    check("t1_busy_cycles", 160'(busy_cnt), 160'(LAT));
    check("t1_dec", ch_dec, 160'({NUM_CH{20'h49998}}));
    check("t1_sig", 160'(ch_sig), 160'({NUM_CH{8'd43}}));
    repeat (3) step();

    // Sign and magnitude corner values
    load_frame(16'h8000, 16'hFFFF, 16'h0000, 16'h4000, 16'hC000, 16'h0001, 16'h1234, 16'h8001);
    run_frame("t2");
    t2_dec = '{20'h50000, 20'h00001, 20'h00000, 20'h25000, 20'h25000};
    t2_sig = '{8'd45, 8'd45, 8'd43, 8'd43, 8'd45};
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_dec_ch%0d", i), 160'(ch_dec[20*i +: 20]), 160'(t2_dec[i]));
      check($sformatf("t2_sig_ch%0d", i), 160'(ch_sig[8*i +: 8]), 160'(t2_sig[i]));
    end
    repeat (2) step();

    // Second strobe while busy is dropped with an overrun pulse
    load_frame(16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000);
    clear_counts();
    pulse_valid();
    load_frame(16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000);
    repeat (49) step();
    ad_valid = 1'b1;
    step();
    ad_valid = 1'b0;
    check("t3_overrun_at", 160'(overrun), 160'(1'b1));
    wait_fd();
    repeat (5) step();
    check("t3_fd_count", 160'(fd_cnt), 160'(1));
    check("t3_ov_count", 160'(ov_cnt), 160'(1));
    check("t3_dec", ch_dec, 160'({NUM_CH{20'h25000}}));
    check("t3_sig", 160'(ch_sig), 160'({NUM_CH{8'd43}}));

    // Mid-frame reset clears outputs and drops the frame
    load_frame(16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'hF000, 16'hE000, 16'hD000, 16'hA000);
    clear_counts();
    pulse_valid();
    repeat (79) step();
    ad_reset = 1'b1;
    step();
    ad_reset = 1'b0;
    check("t5_busy", 160'(busy), 160'(1'b0));
    check("t5_dec", ch_dec, 160'(0));
    check("t5_sig", 160'(ch_sig), 160'({NUM_CH{8'd43}}));
    repeat (170) step();
    check("t5_no_fd", 160'(fd_cnt), 160'(0));

    // Reset and strobe together: reset wins, nothing accepted
    ad_reset = 1'b1;
    ad_valid = 1'b1;
    step();
    ad_reset = 1'b0;
    ad_valid = 1'b0;
    check("rst_wins_busy", 160'(busy), 160'(1'b0));
    repeat (3) step();
    run_frame("t5b");

    // Back-to-back frames at the minimum period
    repeat (2) step();
    load_frame(16'h0100, 16'hFF00, 16'h0200, 16'hFE00, 16'h7000, 16'h9000, 16'h0003, 16'hFFFD);
    clear_counts();
    pulse_valid();
    repeat (LAT) step();
    load_frame(16'h2222, 16'hDDDE, 16'h0010, 16'hFFF0, 16'h6000, 16'hA000, 16'h0005, 16'h8888);
    pulse_valid();
    check("t6_second_accept", 160'(busy), 160'(1'b1));
    wait_fd();
    repeat (3) step();
    check("t6_fd_count", 160'(fd_cnt), 160'(2));
    check("t6_fd_gap", 160'(last_fd - prev_fd), 160'(162));
    check("t6_ov_count", 160'(ov_cnt), 160'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
